// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The requester drives start/data/sign_en; the converter returns status and the packed BCD result.
interface bin2bcd_seq_if #(
    parameter int DATA_W  = 20,
    parameter int DIG_NUM = 6
);
    logic                   start;
    logic [DATA_W-1:0]      data;
    logic                   sign_en;
    logic                   busy;
    logic                   done;
    logic [4*DIG_NUM-1:0]   bcd_out;
    logic                   neg;
    logic                   overflow;
    logic [3:0]             lead_num;

    modport master (
        output start, data, sign_en,
        input  busy, done, bcd_out, neg, overflow, lead_num
    );

    modport slave (
        input  start, data, sign_en,
        output busy, done, bcd_out, neg, overflow, lead_num
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with two's-complement support, saturation on overflow and a significant-digit count.
module bin2bcd_seq #(
    parameter int DATA_W  = 20,
    parameter int DIG_NUM = 6
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int BCD_W = 4 * DIG_NUM;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t             state_q;
    logic [SR_W-1:0]    shiftReg_q;
    logic [CNT_W-1:0]   bitCnt_q;
    logic               ovfSticky_q;
    logic               negFlag_q;
    logic               busy_q;
    logic               done_q;
    logic               neg_q;
    logic               overflow_q;
    logic [BCD_W-1:0]   bcdOut_q;
    logic [3:0]         leadNum_q;

    logic               negIn;
    logic [DATA_W-1:0]  magnitude;
    logic [BCD_W-1:0]   bcdField;
    logic [BCD_W-1:0]   bcdAdj;
    logic [SR_W-1:0]    shiftReg_d;
    logic               shiftOut;
    logic               lastBit;
    logic [BCD_W-1:0]   bcdOut_d;
    logic [3:0]         leadNum_d;

    // Negation wraps in DATA_W bits, so the most negative input maps to 2^(DATA_W-1) unsigned.
    assign negIn     = bus.sign_en & bus.data[DATA_W-1];
    assign magnitude = negIn ? ((~bus.data) + DATA_W'(1)) : bus.data;

    assign bcdField  = shiftReg_q[SR_W-1 -: BCD_W];

    always_comb begin
        bcdAdj = bcdField;
        for (int k = 0; k < DIG_NUM; k++) begin
            if (bcdField[4*k +: 4] > 4'd4) begin
                bcdAdj[4*k +: 4] = bcdField[4*k +: 4] + 4'd3;
            end
        end
    end

    // Digits never exceed 9 before adjust, so the per-digit +3 cannot carry across digits.
    assign shiftOut   = bcdAdj[BCD_W-1];
    assign shiftReg_d = {bcdAdj[BCD_W-2:0], shiftReg_q[DATA_W-1:0], 1'b0};
    assign lastBit    = (bitCnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        leadNum_d = 4'd1;
        for (int k = 0; k < DIG_NUM; k++) begin
            if (bcdField[4*k +: 4] != 4'd0) begin
                leadNum_d = 4'(k + 1);
            end
        end
        bcdOut_d = bcdField;
        if (ovfSticky_q) begin
            bcdOut_d  = {DIG_NUM{4'h9}};
            leadNum_d = 4'(DIG_NUM);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            bitCnt_q    <= '0;
            ovfSticky_q <= 1'b0;
            negFlag_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            neg_q       <= 1'b0;
            overflow_q  <= 1'b0;
            bcdOut_q    <= '0;
            leadNum_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q     <= CONV;
                        busy_q      <= 1'b1;
                        shiftReg_q  <= {{BCD_W{1'b0}}, magnitude};
                        bitCnt_q    <= '0;
                        ovfSticky_q <= 1'b0;
                        negFlag_q   <= negIn;
                    end
                end
                CONV: begin
                    shiftReg_q  <= shiftReg_d;
                    ovfSticky_q <= ovfSticky_q | shiftOut;
                    bitCnt_q    <= bitCnt_q + CNT_W'(1);
                    if (lastBit) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcdOut_q   <= bcdOut_d;
                    leadNum_q  <= leadNum_d;
                    overflow_q <= ovfSticky_q;
                    neg_q      <= negFlag_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcdOut_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = overflow_q;
    assign bus.lead_num = leadNum_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a six-digit and a five-digit instance share stimulus and are
// checked every cycle against an arithmetic model, plus directed literal expectations.
module tb_bin2bcd_seq;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   cmpEn  = 1'b0;
    int   lat;

    bin2bcd_seq_if #(.DATA_W(20), .DIG_NUM(6)) ifA ();
    bin2bcd_seq_if #(.DATA_W(20), .DIG_NUM(5)) ifB ();

    bin2bcd_seq #(.DATA_W(20), .DIG_NUM(6)) dutA (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (ifA)
    );

    bin2bcd_seq #(.DATA_W(20), .DIG_NUM(5)) dutB (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (ifB)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [39:0] bcd;
        logic        neg;
        logic        ovf;
        logic [3:0]  lead;
    } exp_t;

    // Decimal result computed with plain integer arithmetic.
    function automatic exp_t modelConv(input logic [19:0] d, input logic se, input int dig);
        exp_t   e;
        longint mag;
        longint lim;
        longint v;
        e     = '0;
        e.neg = se & d[19];
        mag   = e.neg ? ((longint'(1) << 20) - longint'(d)) : longint'(d);
        lim   = 1;
        for (int i = 0; i < dig; i++) lim = lim * 10;
        if (mag >= lim) begin
            e.ovf  = 1'b1;
            e.lead = 4'(dig);
            for (int i = 0; i < dig; i++) e.bcd[4*i +: 4] = 4'd9;
        end else begin
            v      = mag;
            e.lead = 4'd1;
            for (int i = 0; i < dig; i++) begin
                if (v % 10 != 0) e.lead = 4'(i + 1);
                e.bcd[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return e;
    endfunction

    int   mBusyCnt [2];
    bit   mDone    [2];
    exp_t mOut     [2];
    exp_t pend     [2];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mBusyCnt[k] <= 0;
                mDone[k]    <= 1'b0;
                mOut[k]     <= '0;
                pend[k]     <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mDone[k] <= 1'b0;
                if (mBusyCnt[k] != 0) begin
                    mBusyCnt[k] <= mBusyCnt[k] - 1;
                    if (mBusyCnt[k] == 1) begin
                        mDone[k] <= 1'b1;
                        mOut[k]  <= pend[k];
                    end
                end else if (ifA.start) begin
                    mBusyCnt[k] <= 21;
                    pend[k]     <= modelConv(ifA.data, ifA.sign_en, (k == 0) ? 6 : 5);
                end
            end
        end
    end

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (cmpEn) begin
            checkOutput("cycle A",
                64'({ifA.busy, ifA.done, ifA.neg, ifA.overflow, ifA.lead_num, ifA.bcd_out}),
                64'({mBusyCnt[0] != 0, mDone[0], mOut[0].neg, mOut[0].ovf, mOut[0].lead, mOut[0].bcd[23:0]}));
            checkOutput("cycle B",
                64'({ifB.busy, ifB.done, ifB.neg, ifB.overflow, ifB.lead_num, ifB.bcd_out}),
                64'({mBusyCnt[1] != 0, mDone[1], mOut[1].neg, mOut[1].ovf, mOut[1].lead, mOut[1].bcd[19:0]}));
        end
    end

    task automatic setIn(input logic s, input logic [19:0] d, input logic se);
        ifA.start = s; ifA.data = d; ifA.sign_en = se;
        ifB.start = s; ifB.data = d; ifB.sign_en = se;
    endtask

    // One-cycle start pulse, then count busy cycles; returns in the done cycle's drive slot.
    task automatic applyStimulus(input logic [19:0] d, input logic se, output int cycles);
        setIn(1'b1, d, se);
        @(negedge sys_clk); #1;
        setIn(1'b0, 20'($urandom), 1'($urandom));
        cycles = 0;
        while (ifA.busy && cycles < 100) begin
            cycles++;
            @(negedge sys_clk); #1;
        end
    endtask

    task automatic waitDone(input string nm);
        int n = 0;
        while (!ifA.done && n < 100) begin
            @(negedge sys_clk); #1;
            n++;
        end
        checkOutput({nm, " done seen"}, 64'(ifA.done), 64'd1);
    endtask

    task automatic checkA(input string nm, input logic ov, input logic ng, input logic [3:0] ld, input logic [23:0] bcd);
        checkOutput({nm, " A"}, 64'({ifA.done, ifA.overflow, ifA.neg, ifA.lead_num, ifA.bcd_out}),
                    64'({1'b1, ov, ng, ld, bcd}));
    endtask

    task automatic checkB(input string nm, input logic ov, input logic ng, input logic [3:0] ld, input logic [19:0] bcd);
        checkOutput({nm, " B"}, 64'({ifB.done, ifB.overflow, ifB.neg, ifB.lead_num, ifB.bcd_out}),
                    64'({1'b1, ov, ng, ld, bcd}));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seenDone;
        setIn(1'b0, 20'd0, 1'b0);
        sys_rst_n = 1'b1;
        #3 sys_rst_n = 1'b0;
        #1 cmpEn = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;
        checkOutput("reset A", 64'({ifA.busy, ifA.done, ifA.neg, ifA.overflow, ifA.lead_num, ifA.bcd_out}), 64'd0);
        checkOutput("reset B", 64'({ifB.busy, ifB.done, ifB.neg, ifB.overflow, ifB.lead_num, ifB.bcd_out}), 64'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk); #1;

        applyStimulus(20'd999999, 1'b0, lat);
        checkOutput("latency 999999", 64'(lat), 64'd21);
        checkA("999999", 1'b0, 1'b0, 4'd6, 24'h999999);
        checkB("999999", 1'b1, 1'b0, 4'd5, 20'h99999);

        applyStimulus(20'd0, 1'b0, lat);
        checkA("zero", 1'b0, 1'b0, 4'd1, 24'h000000);
        checkB("zero", 1'b0, 1'b0, 4'd1, 20'h00000);
        applyStimulus(20'd1234, 1'b0, lat);
        checkOutput("latency back-to-back", 64'(lat), 64'd21);
        checkA("1234", 1'b0, 1'b0, 4'd4, 24'h001234);
        checkB("1234", 1'b0, 1'b0, 4'd4, 20'h01234);

        applyStimulus(20'd1000000, 1'b0, lat);
        checkA("1000000", 1'b1, 1'b0, 4'd6, 24'h999999);
        checkB("1000000", 1'b1, 1'b0, 4'd5, 20'h99999);
        applyStimulus(20'd100000, 1'b0, lat);
        checkA("100000", 1'b0, 1'b0, 4'd6, 24'h100000);
        checkB("100000", 1'b1, 1'b0, 4'd5, 20'h99999);
        applyStimulus(20'd99999, 1'b0, lat);
        checkA("99999", 1'b0, 1'b0, 4'd5, 24'h099999);
        checkB("99999", 1'b0, 1'b0, 4'd5, 20'h99999);

        applyStimulus(20'hFFFFF, 1'b1, lat);
        checkA("signed -1", 1'b0, 1'b1, 4'd1, 24'h000001);
        checkB("signed -1", 1'b0, 1'b1, 4'd1, 20'h00001);
        applyStimulus(20'h80000, 1'b1, lat);
        checkA("signed min", 1'b0, 1'b1, 4'd6, 24'h524288);
        checkB("signed min", 1'b1, 1'b1, 4'd5, 20'h99999);
        applyStimulus(20'h7FFFF, 1'b1, lat);
        checkA("signed max", 1'b0, 1'b0, 4'd6, 24'h524287);
        checkB("signed max", 1'b1, 1'b0, 4'd5, 20'h99999);
        applyStimulus(20'hFFFFF, 1'b0, lat);
        checkA("unsigned FFFFF", 1'b1, 1'b0, 4'd6, 24'h999999);

        setIn(1'b1, 20'd111, 1'b0);
        repeat (5) begin
            @(negedge sys_clk); #1;
        end
        setIn(1'b1, 20'd222, 1'b0);
        waitDone("held first");
        checkA("held first", 1'b0, 1'b0, 4'd3, 24'h000111);
        @(negedge sys_clk); #1;
        setIn(1'b0, 20'd0, 1'b0);
        waitDone("held second");
        checkA("held second", 1'b0, 1'b0, 4'd3, 24'h000222);

        setIn(1'b1, 20'd4321, 1'b0);
        @(negedge sys_clk); #1;
        setIn(1'b0, 20'd0, 1'b0);
        repeat (9) begin
            @(negedge sys_clk); #1;
        end
        sys_rst_n = 1'b0;
        #1;
        checkOutput("abort reset A", 64'({ifA.busy, ifA.done, ifA.neg, ifA.overflow, ifA.lead_num, ifA.bcd_out}), 64'd0);
        checkOutput("abort reset B", 64'({ifB.busy, ifB.done, ifB.neg, ifB.overflow, ifB.lead_num, ifB.bcd_out}), 64'd0);
        @(negedge sys_clk); #1;
        sys_rst_n = 1'b1;
        seenDone = 1'b0;
        repeat (30) begin
            @(negedge sys_clk); #1;
            seenDone = seenDone | ifA.done | ifB.done;
        end
        checkOutput("abort no done", 64'(seenDone), 64'd0);
        applyStimulus(20'd4321, 1'b0, lat);
        checkOutput("latency after reset", 64'(lat), 64'd21);
        checkA("after reset", 1'b0, 1'b0, 4'd4, 24'h004321);
        checkB("after reset", 1'b0, 1'b0, 4'd4, 20'h04321);

        repeat (3) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
Start/busy/done handshake; optional two's-complement input with sign output.
Saturates with an overflow flag when the magnitude exceeds the digit count.
Reports the number of significant digits so the downstream segment-display scanner can blank leading zeros.

Parameters:
DATA_W, 20, binary input width in bits; legal range 4..32.
DIG_NUM, 6, number of BCD digits produced; legal range 1..10.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
start  input  1  conversion request; sampled only when busy=0.
data  input  DATA_W  binary value; sampled on the edge that accepts start.
sign_en  input  1  1 = treat data as two's complement; sampled with data.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse; results are valid from this cycle.
bcd_out  output  4*DIG_NUM  packed BCD; digit 0 (units) in [3:0], digit k in [4k+3:4k].
neg  output  1  result is negative; only possible when sign_en=1.
overflow  output  1  magnitude >= 10^DIG_NUM.
lead_num  output  4  significant digits in bcd_out, 1..DIG_NUM.

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, bcd_out=0, neg=0, overflow=0, lead_num=0.
  - Internal shift register, bit counter and sticky overflow cleared.
  - A conversion in flight is aborted and produces no done.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - start=1 at edge E0 → CONV; busy=1.
  - Magnitude loaded into the low DATA_W bits of the shift register; BCD field cleared; bit counter=0; sticky overflow=0.
  - Internal negative flag = sign_en & data[DATA_W-1].
  - When the flag is set, magnitude = (~data + 1) truncated to DATA_W bits, taken as unsigned. The most negative value 2^(DATA_W-1) is represented exactly.
- CONV, one edge per bit, E1..E_DATA_W:
  - Each BCD digit > 4 gets +3 (combinational).
  - The whole {BCD, binary} register then shifts left by 1 on the same edge.
  - The bit shifted out of the top BCD digit ORs into sticky overflow.
  - Counter increments. After DATA_W shifts → DONE.
- DONE, edge E_DATA_W+1:
  - Register the outputs, assert done=1 for exactly one cycle, deassert busy, return to IDLE.
  - If sticky overflow=0: bcd_out = BCD field.
  - If sticky overflow=1: bcd_out = all digits 9, overflow=1.
  - neg = internal negative flag.
  - lead_num = 1 + index of the highest nonzero digit. lead_num=1 for zero. lead_num=DIG_NUM on overflow.
- Latency: start accepted at E0, done high in the cycle following edge E_DATA_W+1, i.e. DATA_W+1 edges. busy high for DATA_W+1 cycles.
- start while busy=1 is ignored; it is not queued.
- start asserted in the done cycle (busy=0) is accepted, giving back-to-back conversions with no gap.
- Outputs hold their last value between done pulses. They change only at a DONE edge or at reset.
- data and sign_en are don't-care except on the accepting edge.
- sign_en=0: data is unsigned and neg is always 0.
- Width rules:
  - Shift register width = 4*DIG_NUM + DATA_W.
  - Add-3 performed on 4-bit digits; no carry into the next digit, since pre-shift digits are <= 9.
  - lead_num is zero-extended to 4 bits.

Test Plan:
- Defaults, sign_en=0, data=999999, start 1 cycle → busy high 21 cycles; done at E21; bcd_out=24'h999999, lead_num=6, overflow=0, neg=0.
- data=0 → bcd_out=0, lead_num=1, done after 21 edges; then data=20'd1234 back-to-back, start held in the done cycle → second done 21 edges later with bcd_out=24'h001234, lead_num=4.
- DATA_W=20, DIG_NUM=5, data=100000 → overflow=1, bcd_out=20'h99999, lead_num=5; then data=99999 → overflow=0, bcd_out=20'h99999.
- sign_en=1:
  - data=20'hFFFFF → neg=1, bcd_out=24'h000001.
  - data=20'h80000 → neg=1, bcd_out=24'h524288.
  - data=20'h7FFFF → neg=0, bcd_out=24'h524287.
- start=1 held continuously with data changed at cycle 5 → only the data captured at E0 is converted; a new conversion starts in the done cycle with the current data.
- sys_rst_n pulsed low at E10 of a conversion → all outputs 0 immediately; no done. A start after release → correct result with normal 21-edge latency.
